// File: rtl/ahb_sub_regbank.sv
// AHB-Lite subordinate that maps a DEPTH-word window onto a ready-handshaked register port.
// Define AHB_SUB_BURST_CHK_EN to add SEQ-beat address/attribute tracking for bursts.
module ahb_sub_regbank #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 16,
    parameter int                WAIT_MAX  = 15
) (
    input  logic                       hclk,
    input  logic                       hrstn,
    input  logic                       hsel,
    input  logic [ADDR_W-1:0]          haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic [2:0]                 hburst,
    input  logic [DATA_W-1:0]          hwdata,
    input  logic                       hready,
    output logic [DATA_W-1:0]          hrdata,
    output logic                       hreadyOut,
    output logic                       hresp,
    output logic [$clog2(DEPTH)-1:0]   reg_addr,
    output logic                       reg_wr_en,
    output logic                       reg_rd_en,
    output logic [DATA_W/8-1:0]        reg_be,
    output logic [DATA_W-1:0]          reg_wdata,
    input  logic [DATA_W-1:0]          reg_rdata,
    input  logic                       reg_ready
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LOG2_B = $clog2(BYTES);
    localparam int AW     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] WIN    = (ADDR_W + 1)'(DEPTH * BYTES);
    localparam logic [ADDR_W:0] BASE_X = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] LIMIT  = BASE_X + WIN;

    typedef enum logic [1:0] {IDLE, XFER, ERR1, ERR2} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [AW-1:0]       addr_q;
    logic [BYTES-1:0]    be_q;
    logic                write_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                accept, acc_err, burst_err, misaligned, in_range, rd_done;

    function automatic logic [BYTES-1:0] calc_be(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
        logic [BYTES-1:0] be;
        int off, nb;
        off = int'(a & ADDR_W'(BYTES - 1));
        nb  = 1 << sz;
        be  = '0;
        for (int b = 0; b < BYTES; b++) be[b] = (b >= off) && (b < off + nb);
        return be;
    endfunction

    assign hreadyOut = (state_q == XFER) ? reg_ready : (state_q != ERR1);
    assign hresp     = (state_q == ERR1) || (state_q == ERR2);
    assign reg_wr_en = (state_q == XFER) && write_q;
    assign reg_rd_en = (state_q == XFER) && !write_q;
    assign reg_addr  = addr_q;
    assign reg_be    = be_q;
    assign reg_wdata = hwdata;

    // Read data is forwarded in the completing cycle so it is valid while hreadyOut is high.
    assign rd_done = (state_q == XFER) && reg_ready && !write_q;
    assign hrdata  = rd_done ? reg_rdata : rdata_q;

    assign accept     = hsel && hready && htrans[1] && hreadyOut;
    assign misaligned = (haddr & ADDR_W'((1 << hsize) - 1)) != '0;
    assign in_range   = ({1'b0, haddr} >= BASE_X) && ({1'b0, haddr} < LIMIT);
    assign acc_err    = (hsize > 3'(LOG2_B)) || misaligned || !in_range || burst_err;

`ifdef AHB_SUB_BURST_CHK_EN
    logic [ADDR_W-1:0] exp_addr_q;
    logic [2:0]        exp_size_q, exp_burst_q;
    logic              exp_write_q, bact_q;

    // WRAPx bursts wrap within a (beats * bytes-per-beat) aligned block.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] sz, input logic [2:0] bt);
        logic [ADDR_W-1:0] inc, bmask;
        inc = ADDR_W'(1) << sz;
        case (bt)
            3'd2:    bmask = (inc << 2) - ADDR_W'(1);
            3'd4:    bmask = (inc << 3) - ADDR_W'(1);
            3'd6:    bmask = (inc << 4) - ADDR_W'(1);
            default: bmask = '0;
        endcase
        if (bmask == '0) return a + inc;
        return (a & ~bmask) | ((a + inc) & bmask);
    endfunction

    assign burst_err = (htrans == 2'b11) &&
                       (!bact_q || haddr != exp_addr_q || hsize != exp_size_q || hwrite != exp_write_q);

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            exp_addr_q  <= '0;
            exp_size_q  <= '0;
            exp_burst_q <= '0;
            exp_write_q <= 1'b0;
            bact_q      <= 1'b0;
        end else if (accept) begin
            if (acc_err) begin
                bact_q <= 1'b0;
            end else if (htrans == 2'b10) begin
                bact_q      <= (hburst != 3'b000);
                exp_size_q  <= hsize;
                exp_write_q <= hwrite;
                exp_burst_q <= hburst;
                exp_addr_q  <= next_addr(haddr, hsize, hburst);
            end else begin
                exp_addr_q  <= next_addr(haddr, exp_size_q, exp_burst_q);
            end
        end else if (hsel && hready && hreadyOut && htrans == 2'b00) begin
            bact_q <= 1'b0;
        end
    end
`else
    logic unused_burst;
    assign burst_err    = 1'b0;
    assign unused_burst = ^{hburst, htrans[0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, ERR2: state_d = accept ? (acc_err ? ERR1 : XFER) : IDLE;
            XFER: begin
                if (reg_ready) begin
                    cnt_d   = '0;
                    state_d = accept ? (acc_err ? ERR1 : XFER) : IDLE;
                end else if (cnt_q + 8'd1 == 8'(WAIT_MAX)) begin
                    cnt_d   = '0;
                    state_d = ERR1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= haddr[LOG2_B +: AW];
                be_q    <= calc_be(haddr, hsize);
                write_q <= hwrite;
            end
            if (rd_done) rdata_q <= reg_rdata;
        end
    end
endmodule

// File: tb/tb_ahb_sub_regbank.sv
// Randomized bench for ahb_sub_regbank (DATA_W=32, DEPTH=16, BASE=0, WAIT_MAX=4).
module tb_ahb_sub_regbank;
    localparam int WMAX = 4;

    logic        hclk, hrstn, hsel, hwrite, hready, hreadyOut, hresp;
    logic [31:0] haddr, hwdata, hrdata, reg_wdata, reg_rdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  reg_addr, reg_be;
    logic        reg_wr_en, reg_rd_en, reg_ready;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = '0;

    assign hready = hreadyOut;

    ahb_sub_regbank #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0), .DEPTH(16), .WAIT_MAX(WMAX)) dut (
        .hclk(hclk), .hrstn(hrstn), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready), .hrdata(hrdata),
        .hreadyOut(hreadyOut), .hresp(hresp), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en), .reg_be(reg_be), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_ready(reg_ready)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One single-beat transfer; the peripheral raises reg_ready on data-phase cycle waitc.
    task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                        input logic [31:0] wd, input int waitc, input logic [31:0] rd);
        bit         legal, to, done;
        int         n, strobes, lows, errs;
        logic [3:0] exp_be;
        legal  = (sz <= 3'd2) && ((a & ((32'd1 << sz) - 32'd1)) == 0) && (a < 32'h40);
        to     = legal && (waitc >= WMAX);
        exp_be = 4'(((1 << (1 << sz)) - 1) << (a % 4));
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr; hburst = 3'b000;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        n = 0; strobes = 0; lows = 0; errs = 0; done = 0;
        while (!done && n < 40) begin
            @(negedge hclk);
            if (reg_wr_en || reg_rd_en) begin
                if (strobes == 0) begin
                    chk("reg_addr", reg_addr, a[5:2]);
                    chk("reg_be", reg_be, exp_be);
                    chk("direction", reg_wr_en, wr);
                    if (wr) chk("reg_wdata", reg_wdata, wd);
                end
                strobes++;
            end
            reg_ready = (n == waitc);
            reg_rdata = rd;
            #1;
            if (!hreadyOut) lows++;
            if (hresp) errs++;
            if (hreadyOut) begin
                done = 1;
                chk("final_hresp", hresp, !legal || to);
                if (legal && !to && !wr) chk("hrdata", hrdata, rd);
            end
            n++;
        end
        if (!done) chk("xfer_bound", 0, 1);
        @(posedge hclk); #1;
        reg_ready = 1'b0;
        chk("strobe_cycles", strobes, legal ? (to ? WMAX : waitc + 1) : 0);
        chk("wait_cycles", lows, legal ? (to ? WMAX + 1 : waitc) : 1);
        chk("err_cycles", errs, (!legal || to) ? 2 : 0);
        if (legal && !to && !wr) last_rd = rd;
        chk("hrdata_hold", hrdata, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  bt[6];
        logic [31:0] ba[6];
        logic [31:0] a, pa, pd;
        logic [2:0]  sz;
        bit          pv;
        int          nstrobe;
        bt = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00};
        ba = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h0};

        hrstn = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = '0; hwrite = 1'b0;
        hburst = '0; hwdata = '0; reg_ready = 1'b0; reg_rdata = '0;
        repeat (2) @(posedge hclk); #1;
        chk("rst_ready_resp", {hreadyOut, hresp}, 2'b10);
        chk("rst_strobes", {reg_wr_en, reg_rd_en}, 2'b00);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_be_addr", {reg_be, reg_addr}, 8'h00);
        hrstn = 1'b1;
        @(posedge hclk); #1;

        xfer(32'h8, 3'd2, 1'b1, 32'hDEADBEEF, 0, 32'h0);
        xfer(32'h5, 3'd0, 1'b0, 32'h0, 3, 32'h00AB0000);
        xfer(32'h0, 3'd3, 1'b0, 32'h0, 0, 32'h0);
        xfer(32'h40, 3'd2, 1'b0, 32'h0, 0, 32'h0);
        xfer(32'h6, 3'd2, 1'b1, 32'h1, 1, 32'h0);
        xfer(32'h3E, 3'd1, 1'b1, 32'hCAFE0000, 1, 32'h0);
        xfer(32'h10, 3'd2, 1'b1, 32'h55AA55AA, 6, 32'h0);
        xfer(32'h14, 3'd2, 1'b0, 32'h0, 0, 32'h12345678);

        // Reset in the middle of a waiting write.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; reg_ready = 1'b0;
        @(negedge hclk); #1;
        chk("midrst_pre_strobe", reg_wr_en, 1);
        hrstn = 1'b0; #1;
        chk("midrst_resp", {hreadyOut, hresp, reg_wr_en}, 3'b100);
        @(posedge hclk); #1;
        hrstn = 1'b1;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            chk("midrst_no_strobe", {reg_wr_en, reg_rd_en}, 2'b00);
        end
        chk("midrst_hrdata", hrdata, 0);
        @(posedge hclk); #1;

        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(0, 9) == 0) ? (32'h40 + ($urandom % 64)) : ($urandom % 64);
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            xfer(a, sz, 1'($urandom), $urandom, $urandom_range(0, 5), $urandom);
        end

        // INCR4 write burst with a BUSY cycle between beats 2 and 3.
        reg_ready = 1'b1; pv = 0; pa = '0; pd = '0; nstrobe = 0;
        for (int c = 0; c < 6; c++) begin
            hsel = 1'b1; htrans = bt[c]; haddr = ba[c]; hsize = 3'd2; hwrite = 1'b1;
            hburst = 3'b011; hwdata = pd;
            @(negedge hclk); #1;
            chk("burst_strobe", reg_wr_en, pv);
            if (pv) begin
                chk("burst_addr", reg_addr, pa[5:2]);
                chk("burst_wdata", reg_wdata, pd);
                nstrobe++;
            end
            chk("burst_resp", {hreadyOut, hresp}, 2'b10);
            pv = bt[c][1]; pa = ba[c]; pd = $urandom;
            @(posedge hclk); #1;
        end
        hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk); #1;
        chk("burst_end_idle", {reg_wr_en, reg_rd_en}, 2'b00);
        chk("burst_beats", nstrobe, 4);
        @(posedge hclk); #1;

        // Burst whose third beat jumps to 0xC instead of 0x8.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hsize = 3'd2; hwrite = 1'b1; hburst = 3'b011;
        @(posedge hclk); #1;
        htrans = 2'b11; haddr = 32'h4; hwdata = $urandom;
        @(posedge hclk); #1;
        htrans = 2'b11; haddr = 32'hC;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk); #1;
`ifdef AHB_SUB_BURST_CHK_EN
        chk("seq_mismatch_err1", {hreadyOut, hresp, reg_wr_en}, 3'b010);
        @(posedge hclk); #1;
        @(negedge hclk); #1;
        chk("seq_mismatch_err2", {hreadyOut, hresp, reg_wr_en}, 3'b110);
`else
        chk("seq_as_nonseq", {hreadyOut, hresp, reg_wr_en, reg_addr}, {3'b101, 4'd3});
`endif
        @(posedge hclk); #1;
        @(negedge hclk); #1;
        chk("after_burst_idle", {hreadyOut, hresp, reg_wr_en, reg_rd_en}, 4'b1000);
        reg_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
